// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller. Owns HI/LO, sequences multi-cycle
// mult/div ops with a busy counter and raises stall_md for D-stage HI/LO users.
// Ports: clk, reset (sync, active-high), start, md_op[3:0], src_a/src_b[31:0],
//        use_md_D in; busy, hi/lo[31:0], stall_md out.
// Build option: define MDU_MADD_EN to decode the madd/maddu/msub/msubu ops (7-10).
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        use_md_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic is_mul, is_div, accept;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (md_op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV, OP_DIVU:   is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = start & (state_q == S_IDLE) & (is_mul | is_div);

    // Datapath works on the latched operands so the forwarded inputs may move on.
    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow corner.
    logic        div_s;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    assign div_s = (op_q == OP_DIV);
    assign a_mag = (div_s & a_q[31]) ? (32'd0 - a_q) : a_q;
    assign b_mag = (div_s & b_q[31]) ? (32'd0 - b_q) : b_q;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign quo   = (div_s & (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem   = (div_s & a_q[31]) ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    op_d    = md_op;
                    a_d     = src_a;
                    b_d     = src_b;
                end else if (start && md_op == OP_MTHI) begin
                    hi_d = src_a;
                end else if (start && md_op == OP_MTLO) begin
                    lo_d = src_a;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero keeps HI/LO.
                            if (b_q != 32'd0) begin
                                lo_d = quo;
                                hi_d = rem;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
                        OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                        OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    // Covers the accept cycle too, before busy rises.
    assign stall_md = use_md_D & (busy | accept);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against
// a behavioural HI/LO model; honours MDU_MADD_EN like the design.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        use_md_D;
    logic        busy;
    logic [31:0] hi, lo;
    logic        stall_md;

    int errs   = 0;
    int checks = 0;

    logic [31:0] m_hi, m_lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .use_md_D(use_md_D),
        .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic bit is_arith(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
        if (op >= 4'd7 && op <= 4'd10) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Reference result of one op applied to the current model HI/LO.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ps, pu, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = sa * sb;
        pu  = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        case (op)
            4'd1: {m_hi, m_lo} = ps;
            4'd2: {m_hi, m_lo} = pu;
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MADD_EN
            4'd7:  {m_hi, m_lo} = acc + ps;
            4'd8:  {m_hi, m_lo} = acc + pu;
            4'd9:  {m_hi, m_lo} = acc - ps;
            4'd10: {m_hi, m_lo} = acc - pu;
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic u);
        bit ar;
        int n;
        ar = is_arith(op);
        n  = (op == 4'd3 || op == 4'd4) ? DC : MC;
        start = 1'b1; md_op = op; src_a = a; src_b = b; use_md_D = u;
        settle();
        chk("busy_pre", 64'(busy), 64'(0));
        chk("stall_pre", 64'(stall_md), 64'(u & ar));
        model(op, a, b);
        step();
        start = 1'b0;
        md_op = 4'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        if (ar) begin
            for (int k = 0; k < n; k++) begin
                settle();
                chk("busy_run", 64'(busy), 64'(1));
                chk("stall_run", 64'(stall_md), 64'(u));
                step();
            end
        end
        settle();
        chk("busy_done", 64'(busy), 64'(0));
        chk("stall_done", 64'(stall_md), 64'(0));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
        step();
    endtask

    function automatic logic [31:0] pick(input int mode);
        logic [31:0] v;
        case (mode)
            0: v = $urandom;
            1: v = 32'($signed($urandom_range(0, 40)) - 20);
            2: v = 32'd0;
            default: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h8000_0000;
                    1: v = 32'hFFFF_FFFF;
                    2: v = 32'h7FFF_FFFF;
                    default: v = 32'd1;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 4'd0;
        src_a = 32'd0; src_b = 32'd0; use_md_D = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        step();
        step();
        reset = 1'b0;
        settle();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_stall", 64'(stall_md), 64'(0));
        step();

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1);
        chk("multu_hi_const", 64'(hi), 64'd2);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd0, 1'b0);
        chk("divz_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        run_op(4'd5, 32'h1234, 32'd0, 1'b1);
        chk("mthi_const", 64'(hi), 64'h1234);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(4'd0, 32'hDEAD_BEEF, 32'd5, 1'b1);
        run_op(4'd13, 32'hDEAD_BEEF, 32'd5, 1'b1);

        // Reset during the third busy cycle of a divide.
        start = 1'b1; md_op = 4'd3; src_a = 32'd100; src_b = 32'd7;
        use_md_D = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        settle();
        chk("rstrun_busy", 64'(busy), 64'(0));
        chk("rstrun_hi", 64'(hi), 64'(0));
        chk("rstrun_lo", 64'(lo), 64'(0));
        repeat (DC + 2) step();
        settle();
        chk("rstrun_nocommit", 64'({hi, lo}), 64'(0));
        step();

        // Accumulate: result depends on MDU_MADD_EN.
        run_op(4'd5, 32'd0, 32'd0, 1'b0);
        run_op(4'd6, 32'd10, 32'd0, 1'b0);
        run_op(4'd7, 32'd2, 32'd3, 1'b1);
`ifdef MDU_MADD_EN
        chk("madd_lo_const", 64'(lo), 64'd16);
`else
        chk("madd_lo_const", 64'(lo), 64'd10);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = pick($urandom_range(0, 3));
            b  = pick($urandom_range(0, 3));
            run_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
